mm_cmd_master: RTL and testbench

Avalon-MM master front-end that turns a valid/ready command stream into single read/write transactions on the 8-bit-address, 16-bit-data memory-mapped slave bus (`mm`). It holds one transaction outstanding, obeys `waitrequest`, and returns each result on a valid/ready response stream. A cycle timeout aborts a hung slave. The block sits directly upstream of `mm` and drives its address/read/write/writedata and consumes its readdata/waitrequest.

---
 rtl/mm_cmd_master.sv | 120 ++++++++++++
 tb/tb_mm_cmd_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mm_cmd_master.sv
// Avalon-MM master front-end: turns a valid/ready command stream into single
// read/write bus transactions with waitrequest handling and a cycle timeout.
module mm_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RSP
  } state_t;

  // Counter only needs to reach TIMEOUT-1, the value at which the abort fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             cmd_fire;
  logic             xfer_done;
  logic             timed_out;

  assign cmd_ready = (state == S_IDLE) && rst_n;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign xfer_done = (state == S_BUS) && !avm_waitrequest;
  // Completion takes priority: the abort only fires while the slave still stalls.
  assign timed_out = (state == S_BUS) && avm_waitrequest && (TIMEOUT != 0) &&
                     (tmo_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: assigning the default first means every path drives state_nxt, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_fire) state_nxt = S_BUS;
      S_BUS:   if (xfer_done || timed_out) state_nxt = S_RSP;
      S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_data      <= '0;
      rsp_error     <= 1'b0;
      err_count     <= '0;
      tmo_cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            avm_address   <= cmd_address;
            avm_writedata <= cmd_writedata;
            avm_read      <= !cmd_write;
            avm_write     <= cmd_write;
            rsp_write     <= cmd_write;
            tmo_cnt       <= '0;
          end
        end
        S_BUS: begin
          if (xfer_done) begin
            rsp_data  <= avm_read ? avm_readdata : '0;
            rsp_error <= 1'b0;
            rsp_valid <= 1'b1;
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
          end else if (timed_out) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RSP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_cmd_master.sv
// Self-checking bench for mm_cmd_master: directed scenarios plus randomized
// transactions against a per-transaction outcome model and a shadow memory.
module tb_mm_cmd_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_address;
  logic [15:0] cmd_writedata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic [7:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_waitrequest;
  logic [7:0]  err_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] slave_mem [256];
  logic [15:0] ref_mem   [256];
  int          ref_err = 0;
  longint      last_accept_t = 0;

  mm_cmd_master #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_address     (cmd_address),
    .cmd_writedata   (cmd_writedata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_write       (rsp_write),
    .rsp_data        (rsp_data),
    .rsp_error       (rsp_error),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: the slave stalls `waits` strobe cycles, then the
  // response is held `hold` cycles before rsp_ready is given.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                         input int waits, input int hold);
    int          guard;
    int          strobes;
    logic        stall;
    logic        exp_err;
    int          exp_strobes;
    logic [15:0] exp_data;
    logic [15:0] h_data;
    logic        h_write;
    logic        h_err;
    longint      gap;

    exp_err     = (waits >= TMO);
    exp_strobes = exp_err ? TMO : waits + 1;
    exp_data    = (!wr && !exp_err) ? ref_mem[addr] : 16'h0000;
    if (wr && !exp_err) ref_mem[addr] = wd;
    if (exp_err && ref_err < 255) ref_err++;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_writedata = wd;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    gap = ($time - last_accept_t) / 10;
    last_accept_t = $time;
    check("cmd_spacing_ge3", gap >= 3, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = $urandom; cmd_address = $urandom; cmd_writedata = $urandom;

    strobes = 0; guard = 0;
    while (!rsp_valid && guard < 100) begin
      if (avm_read || avm_write) begin
        strobes++;
        check("strobe_kind", {avm_read, avm_write}, {!wr, wr});
        check("avm_address", avm_address, addr);
        if (wr) check("avm_writedata", avm_writedata, wd);
        check("cmd_ready_busy", cmd_ready, 0);
        stall = (strobes <= waits);
        avm_waitrequest = stall;
        avm_readdata    = stall ? 16'($urandom) : slave_mem[addr];
        if (!stall && wr) slave_mem[addr] = wd;
      end else begin
        avm_waitrequest = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    avm_waitrequest = 1'b0;
    check("rsp_valid_seen", rsp_valid, 1);
    check("strobe_dropped", {avm_read, avm_write}, 2'b00);
    check("strobe_cycles", strobes, exp_strobes);
    check("rsp_write", rsp_write, wr);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_error", rsp_error, exp_err);
    check("err_count", err_count, ref_err);

    h_data = rsp_data; h_write = rsp_write; h_err = rsp_error;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      // A competing command is offered while the response is stalled.
      cmd_valid = 1'b1; cmd_write = $urandom; cmd_address = $urandom;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_rsp", {h_write, h_err, h_data}, {rsp_write, rsp_error, rsp_data});
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_no_strobe", {avm_read, avm_write}, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("rsp_consumed", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    int          waits;
    logic        wr;
    logic [7:0]  addr;

    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 16'(i);
      ref_mem[i]   = 16'(i);
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_writedata = '0;
    rsp_ready = 1'b0; avm_readdata = '0; avm_waitrequest = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    #1;
    check("reset_strobes", {avm_read, avm_write}, 2'b00);
    check("reset_avm_address", avm_address, 0);
    check("reset_avm_writedata", avm_writedata, 0);
    check("reset_rsp", {rsp_valid, rsp_write, rsp_error, rsp_data}, 0);
    check("reset_err_count", err_count, 0);
    check("post_reset_cmd_ready", cmd_ready, 1);

    // Directed plan
    run_txn(1'b0, 8'h01, 16'h0000, 3, 0);
    run_txn(1'b1, 8'h01, 16'hBEEF, 0, 0);
    run_txn(1'b0, 8'h01, 16'h0000, 0, 0);
    run_txn(1'b0, 8'h02, 16'h0000, 0, 0);
    run_txn(1'b0, 8'h03, 16'h0000, 0, 0);
    run_txn(1'b0, 8'h03, 16'h0000, 0, 0);
    run_txn(1'b0, 8'h10, 16'h0000, 50, 0);
    run_txn(1'b0, 8'h10, 16'h0000, 50, 0);
    run_txn(1'b0, 8'h04, 16'h0000, TMO - 1, 0);
    run_txn(1'b1, 8'h20, 16'h1234, TMO - 1, 5);
    run_txn(1'b0, 8'h20, 16'h0000, 1, 5);

    // Reset in the middle of a bus transaction
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h05;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; avm_waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_reset_strobe_before", avm_read, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; avm_waitrequest = 1'b0; rsp_ready = 1'b1;
    ref_err = 0;
    check("mid_reset_read", avm_read, 0);
    check("mid_reset_rsp_valid", rsp_valid, 0);
    check("mid_reset_err_count", err_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_reset_no_rsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;
    run_txn(1'b0, 8'h02, 16'h0000, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      wr    = $urandom_range(1);
      addr  = 8'($urandom_range(15));
      waits = ($urandom_range(3) == 0) ? $urandom_range(10, TMO - 2) : $urandom_range(3);
      run_txn(wr, addr, 16'($urandom), waits, $urandom_range(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
